// File: rtl/tx_mii_pkt_mon_if.sv
// Transmit MII beat bundle: data, per-byte control flags, beat valid and
// alignment-marker qualifier.
interface tx_mii_pkt_mon_if #(
    parameter int PARAM_RATE_OP = 4,
    parameter int INTF_CTL_WD   = 1 << (PARAM_RATE_OP + 3),
    parameter int INTF_DATA_WD  = 1 << (PARAM_RATE_OP + 6)
);
    logic [INTF_DATA_WD-1:0] tx_mii_d;
    logic [INTF_CTL_WD-1:0]  tx_mii_c;
    logic                    tx_mii_vld;
    logic                    tx_mii_am;

    modport master (output tx_mii_d, output tx_mii_c, output tx_mii_vld, output tx_mii_am);
    modport slave  (input  tx_mii_d, input  tx_mii_c, input  tx_mii_vld, input  tx_mii_am);
endinterface

// File: rtl/tx_mii_pkt_mon.sv
// Transmit MII packet monitor: tracks start/terminate framing across the words
// of each beat, measures frame length and keeps saturating statistics.
module tx_mii_pkt_mon #(
    parameter int PARAM_RATE_OP = 4,
    parameter int INTF_CTL_WD   = 1 << (PARAM_RATE_OP + 3),
    parameter int INTF_DATA_WD  = 1 << (PARAM_RATE_OP + 6),
    parameter int NW            = INTF_CTL_WD / 8
) (
    input  logic                  tclk,
    input  logic                  rst_n,
    tx_mii_pkt_mon_if.slave       mii,
    input  logic [13:0]           cfg_max_len,
    input  logic                  cfg_clr_stats,
    output logic [$clog2(NW):0]   mon_sop_num,
    output logic [$clog2(NW):0]   mon_eop_num,
    output logic [31:0]           stat_pkt_cnt,
    output logic [31:0]           stat_byte_cnt,
    output logic [31:0]           stat_seq_err_cnt,
    output logic [31:0]           stat_len_err_cnt,
    output logic                  mon_in_pkt
);
    localparam int NUM_WD = $clog2(NW) + 1;

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [13:0]         len_reg, len_next;
    logic [NUM_WD-1:0]   sop_num_reg, eop_num_reg, sop_sum, eop_sum;
    logic [31:0]         pkt_cnt_reg, byte_cnt_reg, seq_err_cnt_reg, len_err_cnt_reg;
    logic [31:0]         pkt_sum, byte_sum, seq_sum, lerr_sum;
    logic [13:0]         flen;
    logic                beat_ok;

    logic [NW-1:0]       w_start, w_term, w_data;
    logic [2:0]          w_term_lane [NW];

    assign beat_ok = mii.tx_mii_vld && !mii.tx_mii_am;

    // Per-word decode; the lowest lane holding a terminate wins.
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        logic [7:0]  c_w;
        logic [63:0] d_w;
        logic        term_hit;
        logic [2:0]  term_lane;

        assign c_w = mii.tx_mii_c[8*gi +: 8];
        assign d_w = mii.tx_mii_d[64*gi +: 64];

        always_comb begin
            term_hit  = 1'b0;
            term_lane = 3'd0;
            for (int b = 7; b >= 0; b--) begin
                if (c_w[b] && (d_w[8*b +: 8] == 8'hFD)) begin
                    term_hit  = 1'b1;
                    term_lane = b[2:0];
                end
            end
        end

        assign w_start[gi]     = c_w[0] && (d_w[7:0] == 8'hFB);
        assign w_term[gi]      = term_hit;
        assign w_term_lane[gi] = term_lane;
        assign w_data[gi]      = (c_w == 8'h00);
    end

    function automatic logic [13:0] len_add(input logic [13:0] a, input logic [3:0] b);
        logic [14:0] s;
        s = {1'b0, a} + {11'b0, b};
        return s[14] ? 14'h3FFF : s[13:0];
    endfunction

    function automatic logic [31:0] cnt_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Walk the words in order; the framing state threads from word to word.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        sop_sum    = '0;
        eop_sum    = '0;
        pkt_sum    = '0;
        byte_sum   = '0;
        seq_sum    = '0;
        lerr_sum   = '0;
        flen       = '0;
        if (beat_ok) begin
            for (int w = 0; w < NW; w++) begin
                if (w_start[w]) begin
                    sop_sum = sop_sum + NUM_WD'(1);
                    if (state_next == IN_PKT) begin
                        seq_sum = seq_sum + 32'd1;
                    end
                    state_next = IN_PKT;
                    len_next   = '0;
                end else if (w_term[w]) begin
                    eop_sum = eop_sum + NUM_WD'(1);
                    if (state_next == IN_PKT) begin
                        flen = len_add(len_next, {1'b0, w_term_lane[w]});
                        if (flen >= 14'd64 && flen <= cfg_max_len) begin
                            pkt_sum  = pkt_sum + 32'd1;
                            byte_sum = byte_sum + {18'b0, flen};
                        end else begin
                            lerr_sum = lerr_sum + 32'd1;
                        end
                        state_next = IDLE;
                        len_next   = '0;
                    end else begin
                        seq_sum = seq_sum + 32'd1;
                    end
                end else if (w_data[w] && state_next == IN_PKT) begin
                    len_next = len_add(len_next, 4'd8);
                end
            end
        end
    end

    always_ff @(posedge tclk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            sop_num_reg     <= '0;
            eop_num_reg     <= '0;
            pkt_cnt_reg     <= '0;
            byte_cnt_reg    <= '0;
            seq_err_cnt_reg <= '0;
            len_err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            sop_num_reg <= sop_sum;
            eop_num_reg <= eop_sum;
            if (cfg_clr_stats) begin
                pkt_cnt_reg     <= '0;
                byte_cnt_reg    <= '0;
                seq_err_cnt_reg <= '0;
                len_err_cnt_reg <= '0;
            end else begin
                pkt_cnt_reg     <= cnt_add(pkt_cnt_reg, pkt_sum);
                byte_cnt_reg    <= cnt_add(byte_cnt_reg, byte_sum);
                seq_err_cnt_reg <= cnt_add(seq_err_cnt_reg, seq_sum);
                len_err_cnt_reg <= cnt_add(len_err_cnt_reg, lerr_sum);
            end
        end
    end

    assign mon_sop_num      = sop_num_reg;
    assign mon_eop_num      = eop_num_reg;
    assign stat_pkt_cnt     = pkt_cnt_reg;
    assign stat_byte_cnt    = byte_cnt_reg;
    assign stat_seq_err_cnt = seq_err_cnt_reg;
    assign stat_len_err_cnt = len_err_cnt_reg;
    assign mon_in_pkt       = (state_reg == IN_PKT);
endmodule

// File: tb/tb_tx_mii_pkt_mon.sv
// Bench for tx_mii_pkt_mon: one single-word and one four-word instance checked
// every cycle against a frame-level model, plus literal expectations.
module tb_tx_mii_pkt_mon;
    logic tclk = 1'b0;
    always #5 tclk = ~tclk;

    logic        rst_n;
    logic [13:0] cfg_max_len;
    logic        cfg_clr_stats;

    tx_mii_pkt_mon_if #(.PARAM_RATE_OP(0)) mii1 ();
    tx_mii_pkt_mon_if #(.PARAM_RATE_OP(2)) mii4 ();

    logic [0:0]  sop1, eop1;
    logic [2:0]  sop4, eop4;
    logic [31:0] pkt1, byt1, seq1, ler1, pkt4, byt4, seq4, ler4;
    logic        inp1, inp4;

    tx_mii_pkt_mon #(.PARAM_RATE_OP(0)) u_dut1 (
        .tclk(tclk), .rst_n(rst_n), .mii(mii1),
        .cfg_max_len(cfg_max_len), .cfg_clr_stats(cfg_clr_stats),
        .mon_sop_num(sop1), .mon_eop_num(eop1),
        .stat_pkt_cnt(pkt1), .stat_byte_cnt(byt1),
        .stat_seq_err_cnt(seq1), .stat_len_err_cnt(ler1),
        .mon_in_pkt(inp1)
    );

    tx_mii_pkt_mon #(.PARAM_RATE_OP(2)) u_dut4 (
        .tclk(tclk), .rst_n(rst_n), .mii(mii4),
        .cfg_max_len(cfg_max_len), .cfg_clr_stats(cfg_clr_stats),
        .mon_sop_num(sop4), .mon_eop_num(eop4),
        .stat_pkt_cnt(pkt4), .stat_byte_cnt(byt4),
        .stat_seq_err_cnt(seq4), .stat_len_err_cnt(ler4),
        .mon_in_pkt(inp4)
    );

    typedef struct {
        bit     in_pkt;
        int     len;
        longint pkt, byts, seq, lerr;
        int     sop, eop;
    } mdl_t;

    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
    localparam logic [71:0] W_START = {8'h01, 64'hD555_5555_5555_55FB};
    localparam logic [71:0] W_IDLE  = {8'hFF, 64'h0707_0707_0707_0707};
    localparam logic [71:0] W_DATA  = {8'h00, 64'hFD00_FB00_1122_3344};

    mdl_t e1, e4;
    int   checks = 0;
    int   errors = 0;

    function automatic longint csat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Frame-level reference: classify each word, then accumulate per-beat totals.
    function automatic mdl_t mdl_step(input mdl_t s, input int nw, input logic [255:0] d,
                                      input logic [31:0] c, input bit vld, input bit am,
                                      input bit clr, input bit rstn, input int maxlen);
        mdl_t n;
        longint p, by, sq, le;
        logic [7:0]  cw;
        logic [63:0] dw;
        int tl, fl;
        n = s; p = 0; by = 0; sq = 0; le = 0;
        n.sop = 0; n.eop = 0;
        if (!rstn) begin
            n = '{default: 0};
            return n;
        end
        if (vld && !am) begin
            for (int w = 0; w < nw; w++) begin
                cw = c[8*w +: 8];
                dw = d[64*w +: 64];
                tl = -1;
                for (int b = 7; b >= 0; b--)
                    if (cw[b] && dw[8*b +: 8] == 8'hFD) tl = b;
                if (cw[0] && dw[7:0] == 8'hFB) begin
                    n.sop++;
                    if (n.in_pkt) sq++;
                    n.in_pkt = 1; n.len = 0;
                end else if (tl >= 0) begin
                    n.eop++;
                    if (n.in_pkt) begin
                        fl = (n.len + tl > 16383) ? 16383 : n.len + tl;
                        if (fl >= 64 && fl <= maxlen) begin p++; by += fl; end
                        else le++;
                        n.in_pkt = 0; n.len = 0;
                    end else sq++;
                end else if (cw == 8'h00 && n.in_pkt) begin
                    n.len = (n.len + 8 > 16383) ? 16383 : n.len + 8;
                end
            end
        end
        if (clr) begin
            n.pkt = 0; n.byts = 0; n.seq = 0; n.lerr = 0;
        end else begin
            n.pkt = csat(n.pkt + p); n.byts = csat(n.byts + by);
            n.seq = csat(n.seq + sq); n.lerr = csat(n.lerr + le);
        end
        return n;
    endfunction

    function automatic logic [71:0] wterm(input int b);
        logic [71:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) begin
            if (l < b) w[8*l +: 8] = 8'h5A;
            else begin
                w[64+l]    = 1'b1;
                w[8*l +: 8] = (l == b) ? 8'hFD : 8'h07;
            end
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("n1_sop", 64'(sop1), 64'(e1.sop));   chk("n1_eop", 64'(eop1), 64'(e1.eop));
        chk("n1_pkt", 64'(pkt1), 64'(e1.pkt));   chk("n1_byte", 64'(byt1), 64'(e1.byts));
        chk("n1_seq", 64'(seq1), 64'(e1.seq));   chk("n1_lerr", 64'(ler1), 64'(e1.lerr));
        chk("n1_inpkt", 64'(inp1), 64'(e1.in_pkt));
        chk("n4_sop", 64'(sop4), 64'(e4.sop));   chk("n4_eop", 64'(eop4), 64'(e4.eop));
        chk("n4_pkt", 64'(pkt4), 64'(e4.pkt));   chk("n4_byte", 64'(byt4), 64'(e4.byts));
        chk("n4_seq", 64'(seq4), 64'(e4.seq));   chk("n4_lerr", 64'(ler4), 64'(e4.lerr));
        chk("n4_inpkt", 64'(inp4), 64'(e4.in_pkt));
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        @(posedge tclk);
        e1 = mdl_step(e1, 1, {192'b0, mii1.tx_mii_d}, {24'b0, mii1.tx_mii_c}, mii1.tx_mii_vld,
                      mii1.tx_mii_am, cfg_clr_stats, rst_n, int'(cfg_max_len));
        e4 = mdl_step(e4, 4, mii4.tx_mii_d, mii4.tx_mii_c, mii4.tx_mii_vld,
                      mii4.tx_mii_am, cfg_clr_stats, rst_n, int'(cfg_max_len));
        @(negedge tclk);
        compare();
        mii1.tx_mii_vld = 1'b0; mii1.tx_mii_am = 1'b0;
        mii4.tx_mii_vld = 1'b0; mii4.tx_mii_am = 1'b0;
        cfg_clr_stats   = 1'b0;
    endtask

    task automatic send1(input logic [71:0] w, input bit vld = 1'b1, input bit am = 1'b0);
        mii1.tx_mii_c = w[71:64]; mii1.tx_mii_d = w[63:0];
        mii1.tx_mii_vld = vld; mii1.tx_mii_am = am;
        tick();
    endtask

    task automatic send4(input logic [71:0] w0, input logic [71:0] w1,
                         input logic [71:0] w2, input logic [71:0] w3);
        mii4.tx_mii_c = {w3[71:64], w2[71:64], w1[71:64], w0[71:64]};
        mii4.tx_mii_d = {w3[63:0], w2[63:0], w1[63:0], w0[63:0]};
        mii4.tx_mii_vld = 1'b1; mii4.tx_mii_am = 1'b0;
        tick();
    endtask

    task automatic frame1(input int ndata, input int tlane);
        send1(W_START);
        repeat (ndata) send1(W_DATA);
        send1(wterm(tlane));
    endtask

    initial begin
        e1 = '{default: 0}; e4 = '{default: 0};
        rst_n = 1'b0; cfg_max_len = 14'd1518; cfg_clr_stats = 1'b0;
        mii1.tx_mii_d = '0; mii1.tx_mii_c = '0; mii1.tx_mii_vld = 1'b0; mii1.tx_mii_am = 1'b0;
        mii4.tx_mii_d = '0; mii4.tx_mii_c = '0; mii4.tx_mii_vld = 1'b0; mii4.tx_mii_am = 1'b0;
        @(negedge tclk);
        tick(); tick();
        chk("reset_pkt", 64'(pkt1), 0); chk("reset_inpkt", 64'(inp4), 0);
        rst_n = 1'b1;
        tick();

        frame1(7, 4);                                    // 60 bytes: runt
        chk("runt60_lerr", 64'(ler1), 1); chk("runt60_pkt", 64'(pkt1), 0);

        send1(W_START); repeat (8) send1(W_DATA); send1(wterm(0));
        chk("f64_eop", 64'(eop1), 1);
        chk("f64_pkt", 64'(pkt1), 1); chk("f64_byte", 64'(byt1), 64);

        frame1(7, 7);                                    // 63 bytes
        chk("runt63_lerr", 64'(ler1), 2);

        send1(W_START); repeat (3) send1(W_DATA);        // restarted mid-frame
        send1(W_START); repeat (12) send1(W_DATA); send1(wterm(4));
        chk("restart_seq", 64'(seq1), 1); chk("restart_pkt", 64'(pkt1), 2);
        chk("restart_byte", 64'(byt1), 164);
        send1(wterm(2));
        chk("lone_term_seq", 64'(seq1), 2);

        send1(W_START); repeat (4) send1(W_DATA);
        send1(wterm(0), 1'b1, 1'b1);                     // alignment marker
        chk("am_eop", 64'(eop1), 0);
        send1(wterm(0), 1'b0, 1'b0);                     // not valid
        repeat (4) send1(W_DATA); send1(wterm(0));
        chk("am_pkt", 64'(pkt1), 3); chk("am_byte", 64'(byt1), 228);

        cfg_max_len = 14'd100;
        frame1(12, 5);
        chk("max101_lerr", 64'(ler1), 3);
        frame1(12, 4);
        chk("max100_pkt", 64'(pkt1), 4); chk("max100_byte", 64'(byt1), 328);

        cfg_max_len = 14'h3FFF;
        frame1(2050, 0);                                 // length saturates at 16383
        chk("lensat_pkt", 64'(pkt1), 5); chk("lensat_byte", 64'(byt1), 16711);
        cfg_max_len = 14'd1518;

        force u_dut1.pkt_cnt_reg = 32'hFFFF_FFFF;
        e1.pkt = CMAX;
        tick();
        release u_dut1.pkt_cnt_reg;
        frame1(8, 0);
        chk("cntsat_pkt", 64'(pkt1), 64'hFFFF_FFFF); chk("cntsat_byte", 64'(byt1), 16775);

        send1(W_START); repeat (8) send1(W_DATA);
        cfg_clr_stats = 1'b1;
        send1(wterm(0));
        chk("clr_pkt", 64'(pkt1), 0); chk("clr_byte", 64'(byt1), 0);
        chk("clr_lerr", 64'(ler1), 0); chk("clr_inpkt", 64'(inp1), 0);

        send1(W_START); send1(W_DATA); send1(W_DATA);
        chk("pre_rst_inpkt", 64'(inp1), 1);
        rst_n = 1'b0; send1(W_DATA);
        chk("rst_inpkt", 64'(inp1), 0); chk("rst_seq", 64'(seq1), 0);
        rst_n = 1'b1;
        send1(wterm(0));
        chk("post_rst_seq", 64'(seq1), 1); chk("post_rst_lerr", 64'(ler1), 0);

        send4(W_IDLE, W_IDLE, W_IDLE, W_START);
        chk("w4_sop", 64'(sop4), 1);
        send4(W_DATA, W_DATA, W_DATA, W_DATA);
        send4(W_DATA, W_DATA, W_DATA, W_DATA);
        send4(wterm(0), W_IDLE, W_START, W_DATA);
        chk("w4_eop", 64'(eop4), 1); chk("w4_sop2", 64'(sop4), 1);
        chk("w4_pkt", 64'(pkt4), 1); chk("w4_byte", 64'(byt4), 64);
        chk("w4_inpkt", 64'(inp4), 1);
        send4(wterm(7), W_IDLE, W_IDLE, W_IDLE);
        chk("w4_lerr15", 64'(ler4), 1);
        send4(W_START, wterm(0), W_START, wterm(3));
        chk("w4_multi_sop", 64'(sop4), 2); chk("w4_multi_eop", 64'(eop4), 2);
        chk("w4_multi_lerr", 64'(ler4), 3);
        send4(wterm(0), wterm(1), W_IDLE, W_IDLE);
        chk("w4_seq2", 64'(seq4), 2); chk("w4_eop2", 64'(eop4), 2);
        send4(W_START, W_DATA, W_DATA, W_DATA);
        send4(W_DATA, W_DATA, W_DATA, W_DATA);
        send4(W_DATA, wterm(0), W_IDLE, W_IDLE);
        chk("w4_span_pkt", 64'(pkt4), 2); chk("w4_span_byte", 64'(byt4), 128);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
